sum_game_engine: RTL

SUM_GAME_ENGINE -- requirements
Module: sum_game_engine

---
 rtl/sum_game_engine.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sum_game_engine.sv
// Password-gated sum-guessing game: each round shows a pseudo-random operand, the player
// loads a guess, and a hit is scored when operand + guess equals Target before the countdown expires.
//
// state   | meaning
// LOCKED  | waiting for a correct password; wrong entries are counted
// IDLE    | logged in, waiting for Start
// PLAY    | round in progress, countdown running
// DONE    | session finished, Score/Sum held until Start or Logout
// LOCKOUT | too many wrong passwords, countdown before LOCKED again
module sum_game_engine #(
  parameter int DATA_W                = 4,
  parameter int NUM_ROUNDS            = 5,
  parameter int TICKS_PER_SEC         = 50000000,
  parameter int TIME_LIMIT            = 9,
  parameter int MAX_ATTEMPTS          = 3,
  parameter int LOCKOUT_SEC           = 15,
  parameter logic [DATA_W-1:0] PASSWORD = DATA_W'('hA),
  localparam int SCW = $clog2(NUM_ROUNDS + 1),
  localparam int TW  = $clog2(((TIME_LIMIT > LOCKOUT_SEC) ? TIME_LIMIT : LOCKOUT_SEC) + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] PWDIn,
  input  logic              Login,
  input  logic              Logout,
  input  logic              Start,
  input  logic [DATA_W-1:0] Player2In,
  input  logic              Player2Load,
  input  logic [DATA_W:0]   Target,
  output logic [DATA_W-1:0] RandNum,
  output logic [DATA_W:0]   Sum,
  output logic [SCW-1:0]    Score,
  output logic [SCW-1:0]    Round,
  output logic [TW-1:0]     SecLeft,
  output logic              GLED,
  output logic              RLED,
  output logic              Hit,
  output logic              Miss,
  output logic [2:0]        State
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = (MAX_ATTEMPTS > 1) ? $clog2(MAX_ATTEMPTS + 1) : 1;

  typedef enum logic [2:0] {
    S_LOCKED  = 3'd0,
    S_IDLE    = 3'd1,
    S_PLAY    = 3'd2,
    S_DONE    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   tick_cnt;
  logic [15:0]     lfsr;
  logic [AW-1:0]   attempts;
  logic [DATA_W:0] sum_new;
  logic            tick, pwd_ok, login_ev, bad_login, lock_trip, logout_ev, lockout_done;
  logic            start_ok, guess, timeout, resolve, last_round, round_load, match;

  // Event decode; Logout masks every other input except while in LOCKOUT.
  always_comb begin
    tick         = (tick_cnt == CW'(TICKS_PER_SEC - 1));
    pwd_ok       = (PWDIn == PASSWORD);
    logout_ev    = Logout && (state_q != S_LOCKOUT);
    login_ev     = (state_q == S_LOCKED) && Login && !Logout;
    bad_login    = login_ev && !pwd_ok;
    lock_trip    = bad_login && (attempts >= AW'(MAX_ATTEMPTS - 1));
    lockout_done = (state_q == S_LOCKOUT) && (SecLeft == '0);
    start_ok     = ((state_q == S_IDLE) || (state_q == S_DONE)) && Start && !Logout;
    sum_new      = {1'b0, RandNum} + {1'b0, Player2In};
    match        = (sum_new == Target);
    guess        = (state_q == S_PLAY) && Player2Load && !Logout;
    // A guess in the expiring cycle wins over the timeout.
    timeout      = (state_q == S_PLAY) && !Logout && !Player2Load &&
                   ((SecLeft == '0) || (tick && (SecLeft == TW'(1))));
    resolve      = guess || timeout;
    last_round   = (Round >= SCW'(NUM_ROUNDS));
    round_load   = start_ok || (resolve && !last_round);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_LOCKED;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOCKED: begin
        if (login_ev) begin
          if (pwd_ok)         state_d = S_IDLE;
          else if (lock_trip) state_d = S_LOCKOUT;
        end
      end
      S_IDLE, S_DONE: begin
        if (logout_ev)     state_d = S_LOCKED;
        else if (start_ok) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (logout_ev)                 state_d = S_LOCKED;
        else if (resolve && last_round) state_d = S_DONE;
      end
      S_LOCKOUT: begin
        if (lockout_done) state_d = S_LOCKED;
      end
      default: state_d = S_LOCKED;
    endcase
  end

  always_comb begin
    State = state_q;
    GLED  = (state_q == S_IDLE) || (state_q == S_PLAY) || (state_q == S_DONE);
    RLED  = !GLED;
  end

  // Seconds prescaler, restarted at every round start and lockout entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                tick_cnt <= '0;
    else if (round_load || lock_trip || tick) tick_cnt <= '0;
    else                                    tick_cnt <= tick_cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               attempts <= '0;
    else if (lockout_done) attempts <= '0;
    else if (login_ev)     attempts <= pwd_ok ? '0 : attempts + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             SecLeft <= '0;
    else if (logout_ev)  SecLeft <= '0;
    else if (lock_trip)  SecLeft <= TW'(LOCKOUT_SEC);
    else if (round_load) SecLeft <= TW'(TIME_LIMIT);
    else if (resolve)    SecLeft <= '0;
    else if (((state_q == S_PLAY) || (state_q == S_LOCKOUT)) && tick && (SecLeft != '0))
      SecLeft <= SecLeft - TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RandNum <= '0;
      Sum     <= '0;
    end else begin
      if (round_load) RandNum <= lfsr[DATA_W-1:0];
      if (guess)      Sum     <= sum_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Score <= '0;
      Round <= '0;
    end else if (logout_ev) begin
      Score <= '0;
      Round <= '0;
    end else if (start_ok) begin
      Score <= '0;
      Round <= SCW'(1);
    end else begin
      if (guess && match)           Score <= Score + SCW'(1);
      if (resolve && !last_round)   Round <= Round + SCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Hit  <= 1'b0;
      Miss <= 1'b0;
    end else begin
      Hit  <= guess && match;
      Miss <= (guess && !match) || timeout;
    end
  end

endmodule
